wifi_tx_arbiter: RTL
====================

Name: wifi_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single wifi UART transmit byte stream between two requesters: port 0 (touchscreen event forwarder) and port 1 (CPU/avalon bridge).
- The grant is held for a whole packet, delimited by `last`.
- An inter-packet gap is inserted after each packet so the wifi module can frame messages.
- A runaway packet is force-released after MAX_BEATS bytes.
- Sits between the requester FIFOs and the wifi UART TX serializer.

Parameters:
- GAP_CYCLES, 16, idle clk cycles inserted after each packet end (0 = no gap).
- MAX_BEATS, 256, maximum bytes per packet before forced release (>=1).
- CNT_W, 16, width of the gap and beat counters; must hold max(GAP_CYCLES, MAX_BEATS).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- s0_data  input  8  requester 0 byte.
- s0_valid  input  1  requester 0 byte valid.
- s0_last  input  1  requester 0 last byte of packet.
- s0_ready  output  1  requester 0 byte accepted.
- s1_data  input  8  requester 1 byte.
- s1_valid  input  1  requester 1 byte valid.
- s1_last  input  1  requester 1 last byte of packet.
- s1_ready  output  1  requester 1 byte accepted.
- tx_data  output  8  byte to UART TX.
- tx_valid  output  1  byte valid to UART TX.
- tx_ready  input  1  UART TX can accept a byte.
- grant  output  2  one-hot current owner; 00 when none.
- busy  output  1  high in any state other than IDLE.
- overrun  output  1  one-cycle pulse on forced release.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - State = IDLE; grant = 00; busy = 0; overrun = 0.
  - tx_valid = 0; s0_ready = s1_ready = 0; tx_data = 0.
  - last_served = 1, so port 0 wins the first tie.
  - Beat and gap counters = 0.
- Reset mid-packet aborts the packet immediately; there is no partial flush.

- Handshake:
  - A beat transfers on a cycle where tx_valid & tx_ready.
  - tx_valid must not depend on tx_ready.
  - A requester may hold valid indefinitely.

- States:
  - IDLE:
    - Outputs: grant = 00; readies = 0; tx_valid = 0.
    - Only s0_valid high -> GRANT0.
    - Only s1_valid high -> GRANT1.
    - Both high -> grant the port != last_served.
    - Neither -> stay in IDLE.
    - The decision is registered: there is one cycle of arbitration latency before the first beat is visible.
  - GRANTn:
    - grant = one-hot n.
    - tx_data = sn_data, tx_valid = sn_valid, sn_ready = tx_ready (combinational pass-through).
    - The other port's ready = 0.
    - The beat counter increments on each transfer.
    - Transfer with sn_last = 1 -> last_served <= n, beat counter <= 0, go to GAP (or IDLE if GAP_CYCLES = 0).
    - Transfer that is beat number MAX_BEATS with sn_last = 0:
      - overrun pulses high for exactly one cycle, registered (the cycle after the transfer).
      - last_served <= n, go to GAP/IDLE.
      - Later bytes from n form a new packet.
    - sn_valid dropping mid-packet keeps the grant; there is no timeout.
  - GAP:
    - grant = 00; readies = 0; tx_valid = 0; busy = 1.
    - Counts GAP_CYCLES cycles, then goes to IDLE.
    - Requests arriving during GAP are held off and arbitrated in IDLE.
- Minimum spacing between the last beat of one packet and the first beat of the next: GAP_CYCLES + 2 cycles (one to leave GRANTn, one for IDLE arbitration).
- Single-byte packet (valid & last on the first beat) is legal and counts as one beat.
- The beat counter never wraps: it saturates at MAX_BEATS via forced release.

Test Plan:
- Reset then s0 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3) with tx_ready = 1 -> grant = 01 from cycle 1; tx_data shows A1,A2,A3 on cycles 1-3; grant = 00 and busy = 1 for 16 cycles; then IDLE with busy = 0.
- s0 and s1 both assert valid in the same cycle after reset, each sending 2-byte packets repeatedly -> packet order is s0, s1, s0, s1; no byte from one port appears inside another's packet.
- tx_ready toggles 1,0,1,0 during an s1 packet 0x10,0x11,0x12 -> each byte is held stable on tx_data while tx_ready = 0; s1_ready mirrors tx_ready; exactly 3 transfers occur; no duplicate or drop.
- MAX_BEATS = 4, s0 streams 6 bytes with last only on byte 6 -> overrun pulses once after byte 4; s0 is re-granted after the gap (s1 idle); bytes 5-6 are sent as a new packet.
- GAP_CYCLES = 0, s1 sends a 1-byte packet with s0 pending -> s0's first byte reaches tx_data exactly 2 cycles after s1's transfer.
- reset asserted while in GRANT0 mid-packet -> next cycle grant = 00, tx_valid = 0, readies = 0; afterwards a tie between s0 and s1 is won by s0.

Source files
------------

// File: rtl/wifi_tx_arbiter.sv
// -----------------------------------------------------------------------------
// wifi_tx_arbiter
//
// Packet-level round-robin arbiter that shares the single wifi UART transmit
// byte stream between two requesters:
//   port 0 - touchscreen event forwarder
//   port 1 - CPU/avalon bridge
//
// The grant is held for a whole packet (delimited by sN_last). An idle gap of
// GAP_CYCLES clocks follows every packet so the wifi module can frame
// messages. A packet longer than MAX_BEATS bytes is force-released and the
// overrun output pulses for one cycle.
//
// Handshake (all ports): a byte moves on any cycle where valid & ready are
// both high. valid never depends on ready; a source may hold valid for as
// long as it likes and must keep data/last stable until the byte moves.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   s0_data/valid/last  - requester 0 byte stream, s0_ready back to it
//   s1_data/valid/last  - requester 1 byte stream, s1_ready back to it
//   tx_data/valid       - byte stream to the UART TX serializer
//   tx_ready            - serializer can accept a byte
//   grant               - one-hot current owner (00 = none)
//   busy                - arbiter not in IDLE
//   overrun             - one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module wifi_tx_arbiter #(
    parameter int GAP_CYCLES = 16,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] BEAT_LIMIT = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] GAP_LIMIT  = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_nxt;
    logic             last_served, last_served_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
    logic             overrun_nxt;
    logic             xfer;
    logic             pkt_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= 1'b1;   // port 0 wins the first tie
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
            beat_cnt    <= beat_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            overrun     <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        beat_cnt_nxt    = beat_cnt;
        gap_cnt_nxt     = gap_cnt;
        overrun_nxt     = 1'b0;
        grant           = 2'b00;
        tx_data         = 8'h00;
        tx_valid        = 1'b0;
        s0_ready        = 1'b0;
        s1_ready        = 1'b0;
        busy            = (state != IDLE);
        xfer            = 1'b0;
        pkt_last        = 1'b0;

        case (state)
            IDLE: begin
                // Port 0 takes it when alone, or on a tie when port 1 went last.
                if (s0_valid && (!s1_valid || last_served)) begin
                    state_nxt = GRANT0;
                end else if (s1_valid) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                grant    = 2'b01;
                tx_data  = s0_data;
                tx_valid = s0_valid;
                s0_ready = tx_ready;
                xfer     = s0_valid && tx_ready;
                pkt_last = s0_last;
            end
            GRANT1: begin
                grant    = 2'b10;
                tx_data  = s1_data;
                tx_valid = s1_valid;
                s1_ready = tx_ready;
                xfer     = s1_valid && tx_ready;
                pkt_last = s1_last;
            end
            GAP: begin
                if (gap_cnt == GAP_LIMIT) begin
                    state_nxt   = IDLE;
                    gap_cnt_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Packet end: either a genuine last byte or the MAX_BEATS-th byte of a
        // runaway packet. Both release the grant the same way; only the runaway
        // case raises overrun. Bytes after a forced release start a new packet.
        if (xfer) begin
            if (pkt_last || (beat_cnt == BEAT_LIMIT)) begin
                overrun_nxt     = !pkt_last;
                last_served_nxt = (state == GRANT1);
                beat_cnt_nxt    = '0;
                gap_cnt_nxt     = '0;
                state_nxt       = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
                beat_cnt_nxt = beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule
